prg_uploader: RTL and testbench

- Reverse path of the PRG loader: snapshots the BASIC program in PET RAM and streams it to the HPS as a .PRG file over the ioctl upload channel.
- Reads the TXTTAB/VARTAB zero-page pointers through the hardware DMA read port.
- Emits a 2-byte little-endian load address, then memory bytes from TXTTAB up to VARTAB-1.
- Sits beside the download loader in the top level, sharing the pet2001hw DMA port with it.

---
 rtl/prg_uploader.sv | 165 ++++++++++++++++
 tb/tb_prg_uploader.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prg_uploader.sv
// prg_uploader: streams the PET BASIC program (TXTTAB..VARTAB-1) to the HPS as a .PRG upload
//
// Ports:
//   clk              system clock
//   reset_n          synchronous reset, active low
//   start            one-cycle request to begin a save
//   busy             high from accepted start until back in IDLE
//   done             one-cycle pulse on successful completion
//   error            sticky bad-pointer flag, cleared by the next accepted start
//   file_size        bytes offered to the HPS (program length + 2-byte load address)
//   dma_addr         DMA read address (holds when idle)
//   dma_rd           one-cycle DMA read strobe
//   dma_din          DMA read data, valid RD_LAT cycles after the strobe
//   ioctl_upload_req request to the HPS to open an upload
//   ioctl_upload     high while the HPS upload is in progress
//   ioctl_rd         HPS read strobe for ioctl_addr
//   ioctl_addr       requested file offset
//   ioctl_din        registered byte for the last accepted ioctl_rd
//   ioctl_wait       stall to the HPS while the byte is being fetched
module prg_uploader #(
    parameter int          RD_LAT   = 1,
    parameter logic [15:0] PTR_BASE = 16'h0028,
    parameter logic [15:0] MAX_END  = 16'h8000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [16:0] file_size,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    input  logic [7:0]  dma_din,
    output logic        ioctl_upload_req,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PTR0  = 3'd1;
    localparam logic [2:0] PTR1  = 3'd2;
    localparam logic [2:0] PTR2  = 3'd3;
    localparam logic [2:0] PTR3  = 3'd4;
    localparam logic [2:0] CHECK = 3'd5;
    localparam logic [2:0] ARMED = 3'd6;
    localparam logic [2:0] FETCH = 3'd7;
    // counter preload: the strobe cycle itself plus RD_LAT cycles until dma_din is sampled
    localparam logic [1:0] LAT = 2'(RD_LAT);

    logic [2:0]  state;
    logic [31:0] ptrs;
    logic [24:0] off;
    logic [1:0]  cnt;
    logic        from_mem;
    logic        upl_q;
    logic [15:0] txt;
    logic [15:0] vtab;
    logic [1:0]  idx;
    logic        upl_fall;
    logic        in_data;
    logic        ptr_bad;
    logic [7:0]  fetch_byte;

    // ptrs holds TXTTAB lo/hi then VARTAB lo/hi, in DMA read order
    assign txt        = ptrs[15:0];
    assign vtab       = ptrs[31:16];
    assign idx        = 2'(state - PTR0);
    assign upl_fall   = upl_q && !ioctl_upload;
    assign in_data    = ioctl_addr >= 25'd2 && ioctl_addr < {8'd0, file_size};
    assign ptr_bad    = txt == 16'd0 || vtab <= txt || vtab > MAX_END;
    // offsets 0/1 carry the load address; past the end of file the HPS gets zeros
    assign fetch_byte = from_mem ? dma_din :
                        off == 25'd0 ? txt[7:0] :
                        off == 25'd1 ? txt[15:8] : 8'h00;
    assign busy       = state != IDLE;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= IDLE;
            ptrs             <= '0;
            off              <= '0;
            cnt              <= '0;
            from_mem         <= 1'b0;
            upl_q            <= 1'b0;
            dma_rd           <= 1'b0;
            dma_addr         <= '0;
            done             <= 1'b0;
            error            <= 1'b0;
            file_size        <= '0;
            ioctl_upload_req <= 1'b0;
            ioctl_din        <= '0;
            ioctl_wait       <= 1'b0;
        end else begin
            dma_rd <= 1'b0;
            done   <= 1'b0;
            upl_q  <= ioctl_upload;
            if (ioctl_upload)
                ioctl_upload_req <= 1'b0;
            case (state)
                IDLE:
                    if (start) begin
                        error    <= 1'b0;
                        state    <= PTR0;
                        dma_rd   <= 1'b1;
                        dma_addr <= PTR_BASE;
                        cnt      <= LAT;
                    end
                PTR0, PTR1, PTR2, PTR3:
                    if (cnt != 2'd0)
                        cnt <= cnt - 2'd1;
                    else begin
                        ptrs[{idx, 3'b000} +: 8] <= dma_din;
                        state <= state + 3'd1;
                        if (state != PTR3) begin
                            dma_rd   <= 1'b1;
                            dma_addr <= PTR_BASE + 16'(idx) + 16'd1;
                            cnt      <= LAT;
                        end
                    end
                CHECK:
                    if (ptr_bad) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        file_size        <= {1'b0, vtab - txt} + 17'd2;
                        ioctl_upload_req <= 1'b1;
                        state            <= ARMED;
                    end
                ARMED:
                    if (upl_fall) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (ioctl_rd) begin
                        off        <= ioctl_addr;
                        ioctl_wait <= 1'b1;
                        from_mem   <= in_data;
                        cnt        <= in_data ? LAT : 2'd0;
                        state      <= FETCH;
                        if (in_data) begin
                            dma_rd   <= 1'b1;
                            dma_addr <= txt + ioctl_addr[15:0] - 16'd2;
                        end
                    end
                FETCH:
                    // an upload closing mid-fetch drops the byte; any late dma_din is ignored in IDLE
                    if (upl_fall) begin
                        ioctl_wait <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end else if (cnt != 2'd0)
                        cnt <= cnt - 2'd1;
                    else begin
                        ioctl_din  <= fetch_byte;
                        ioctl_wait <= 1'b0;
                        state      <= ARMED;
                    end
                default:
                    state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prg_uploader.sv
// tb_prg_uploader: drives two uploaders (RD_LAT 1 and 3) in lockstep against a PET memory model
module tb_prg_uploader;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [1:0]  busy, done, error, dma_rd, upl_req, iwait;
    logic [16:0] fsz [2];
    logic [15:0] daddr [2];
    logic [7:0]  idin [2];
    logic [7:0]  din0, q0, q1, q2;
    logic [7:0]  mem [65536];
    logic [15:0] eq0 [$];
    logic [15:0] eq1 [$];
    int          lat [2] = '{1, 3};
    int          done_cnt [2] = '{0, 0};
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  exp_din = 8'h00;
    logic [16:0] exp_fs = '0;
    logic        exp_err = 1'b0;
    logic        din_known = 1'b0;
    logic        fs_known = 1'b0;
    logic        err_known = 1'b0;
    logic [1:0]  req_seen = 2'b00;

    prg_uploader #(.RD_LAT(1)) u0 (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy[0]), .done(done[0]),
        .error(error[0]), .file_size(fsz[0]), .dma_addr(daddr[0]), .dma_rd(dma_rd[0]),
        .dma_din(din0), .ioctl_upload_req(upl_req[0]), .ioctl_upload(ioctl_upload),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(idin[0]), .ioctl_wait(iwait[0])
    );

    prg_uploader #(.RD_LAT(3)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy[1]), .done(done[1]),
        .error(error[1]), .file_size(fsz[1]), .dma_addr(daddr[1]), .dma_rd(dma_rd[1]),
        .dma_din(q2), .ioctl_upload_req(upl_req[1]), .ioctl_upload(ioctl_upload),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(idin[1]), .ioctl_wait(iwait[1])
    );

    always #5 clk = ~clk;

    // memory with 1- and 3-cycle read pipelines; 5A marks cycles with no read
    always @(posedge clk) begin
        din0 <= dma_rd[0] ? mem[daddr[0]] : 8'h5A;
        q0   <= dma_rd[1] ? mem[daddr[1]] : 8'h5A;
        q1   <= q0;
        q2   <= q1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] m_txt();
        return {mem[16'h0029], mem[16'h0028]};
    endfunction

    function automatic logic [7:0] exp_byte(input logic [24:0] o);
        logic [15:0] t;
        logic [16:0] fs;
        t  = m_txt();
        fs = {1'b0, {mem[16'h002B], mem[16'h002A]} - t} + 17'd2;
        if (o == 25'd0) return t[7:0];
        if (o == 25'd1) return t[15:8];
        if (o < {8'd0, fs}) return mem[16'(t + o[15:0] - 16'd2)];
        return 8'h00;
    endfunction

    // every-cycle comparison of both DUTs against the model state
    always @(negedge clk) begin : cmp
        logic [15:0] a;
        if (reset_n) begin
            for (int k = 0; k < 2; k++) begin
                if (dma_rd[k]) begin
                    if ((k == 0 ? eq0.size() : eq1.size()) == 0)
                        chk($sformatf("dma_rd_unexpected%0d", k), 32'(daddr[k]), 32'hFFFF_FFFF);
                    else begin
                        if (k == 0) a = eq0.pop_front();
                        else a = eq1.pop_front();
                        chk($sformatf("dma_addr%0d", k), 32'(daddr[k]), 32'(a));
                    end
                end
                if (din_known && !iwait[k]) chk($sformatf("ioctl_din%0d", k), 32'(idin[k]), 32'(exp_din));
                if (fs_known) chk($sformatf("file_size%0d", k), 32'(fsz[k]), 32'(exp_fs));
                if (busy[k]) chk($sformatf("error_while_busy%0d", k), 32'(error[k]), 0);
                else if (err_known) chk($sformatf("error%0d", k), 32'(error[k]), 32'(exp_err));
                if (done[k]) begin
                    done_cnt[k]++;
                    chk($sformatf("busy_on_done%0d", k), 32'(busy[k]), 0);
                end
                if (upl_req[k]) req_seen[k] = 1'b1;
            end
        end
    end

    task automatic check_reset(input string name);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_done"}, 32'(done), 0);
        chk({name, "_error"}, 32'(error), 0);
        chk({name, "_dma_rd"}, 32'(dma_rd), 0);
        chk({name, "_req"}, 32'(upl_req), 0);
        chk({name, "_wait"}, 32'(iwait), 0);
        for (int k = 0; k < 2; k++) begin
            chk({name, "_fsz"}, 32'(fsz[k]), 0);
            chk({name, "_daddr"}, 32'(daddr[k]), 0);
            chk({name, "_din"}, 32'(idin[k]), 0);
        end
    endtask

    task automatic set_ptrs(input logic [15:0] t, input logic [15:0] v);
        mem[16'h0028] = t[7:0];
        mem[16'h0029] = t[15:8];
        mem[16'h002A] = v[7:0];
        mem[16'h002B] = v[15:8];
    endtask

    task automatic do_start(output logic bad);
        logic [15:0] t, v;
        logic settled;
        t = m_txt();
        v = {mem[16'h002B], mem[16'h002A]};
        bad = t == 16'd0 || v <= t || v > 16'h8000;
        for (int i = 0; i < 4; i++) begin
            eq0.push_back(16'h0028 + 16'(i));
            eq1.push_back(16'h0028 + 16'(i));
        end
        err_known = 1'b0;
        fs_known = 1'b0;
        req_seen = 2'b00;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        settled = 1'b0;
        for (int i = 0; i < 40 && !settled; i++) begin
            settled = bad ? busy == 2'b00 : upl_req == 2'b11;
            if (!settled) tick(1);
        end
        chk("start_settle", 32'(settled), 1);
        exp_err = bad;
        err_known = 1'b1;
        if (!bad) exp_fs = {1'b0, v - t} + 17'd2;
        fs_known = 1'b1;
        chk("ptr_reads_left", eq0.size() + eq1.size(), 0);
    endtask

    task automatic hps_begin();
        chk("req_before_upload", 32'(upl_req == 2'b11), 1);
        ioctl_upload = 1'b1;
        tick(2);
        chk("req_after_upload", 32'(upl_req), 0);
    endtask

    task automatic hps_read(input logic [24:0] o);
        logic [7:0] eb;
        logic dm;
        logic [1:0] dropped;
        int w [2];
        eb = exp_byte(o);
        dm = o >= 25'd2 && o < {8'd0, exp_fs};
        if (dm) begin
            eq0.push_back(16'(m_txt() + o[15:0] - 16'd2));
            eq1.push_back(16'(m_txt() + o[15:0] - 16'd2));
        end
        din_known = 1'b0;
        ioctl_addr = o;
        ioctl_rd = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        w = '{0, 0};
        dropped = 2'b00;
        for (int i = 0; i < 12 && dropped != 2'b11; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!dropped[k]) begin
                    if (iwait[k]) w[k]++;
                    else begin
                        dropped[k] = 1'b1;
                        chk($sformatf("din_at_wait_drop%0d", k), 32'(idin[k]), 32'(eb));
                    end
                end
            end
            if (dropped != 2'b11) tick(1);
        end
        for (int k = 0; k < 2; k++)
            chk($sformatf("wait_cycles%0d_off%0d", k, o), w[k], dm ? lat[k] + 1 : 1);
        exp_din = eb;
        din_known = 1'b1;
    endtask

    task automatic hps_end();
        int n0 [2];
        n0 = done_cnt;
        ioctl_upload = 1'b0;
        tick(4);
        for (int k = 0; k < 2; k++) chk($sformatf("done_pulses%0d", k), done_cnt[k] - n0[k], 1);
        chk("busy_after_done", 32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        int n0 [2];
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 37 + 5);
        for (int i = 1; i <= 15; i++) mem[16'h0400 + i] = 8'(8'h10 + i);
        tick(3);
        check_reset("reset");
        exp_din = 8'h00; din_known = 1'b1;
        exp_fs = '0; fs_known = 1'b1;
        exp_err = 1'b0; err_known = 1'b1;
        reset_n = 1'b1;
        tick(2);

        // normal 15-byte program at $0401
        set_ptrs(16'h0401, 16'h0410);
        do_start(bad);
        chk("fs_literal0", 32'(fsz[0]), 17);
        chk("fs_literal1", 32'(fsz[1]), 17);
        hps_begin();
        for (int o = 0; o <= 16; o++) begin
            hps_read(25'(o));
            chk($sformatf("seq_literal_off%0d", o), 32'(idin[1]),
                o == 0 ? 32'h01 : o == 1 ? 32'h04 : 32'(8'h0F + o));
        end
        hps_read(25'd20);
        chk("past_end_literal", 32'(idin[0]), 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        chk("start_ignored_busy", 32'(busy), 3);
        hps_read(25'd2);
        chk("reread_literal", 32'(idin[0]), 32'h11);
        hps_end();
        chk("dma_queue_empty_a", eq0.size() + eq1.size(), 0);
        ioctl_addr = 25'd0;
        ioctl_rd = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        tick(3);
        chk("idle_rd_wait", 32'(iwait), 0);
        chk("idle_rd_din", 32'(idin[0]), 32'h11);

        // VARTAB == TXTTAB
        n0 = done_cnt;
        set_ptrs(16'h0401, 16'h0401);
        do_start(bad);
        chk("err_equal", 32'(error), 3);
        chk("err_equal_req", 32'(req_seen), 0);
        chk("err_equal_no_done", done_cnt[0] + done_cnt[1] - n0[0] - n0[1], 0);
        chk("err_equal_fs_kept", 32'(fsz[0]), 17);

        // a valid start clears the sticky error
        set_ptrs(16'h0401, 16'h0410);
        do_start(bad);
        chk("err_cleared", 32'(error), 0);
        hps_begin();
        hps_end();

        // VARTAB beyond end of RAM
        set_ptrs(16'h0401, 16'h8001);
        do_start(bad);
        chk("err_over_max", 32'(error), 3);

        // one-byte program at the top of RAM
        set_ptrs(16'h7FFF, 16'h8000);
        mem[16'h7FFF] = 8'hA5;
        do_start(bad);
        chk("top_fs_literal", 32'(fsz[0]), 3);
        chk("top_no_error", 32'(error), 0);
        hps_begin();
        hps_read(25'd2);
        chk("top_byte_literal", 32'(idin[1]), 32'hA5);
        hps_read(25'd0);
        chk("top_lo_literal", 32'(idin[0]), 32'hFF);
        hps_read(25'd1);
        chk("top_hi_literal", 32'(idin[0]), 32'h7F);
        hps_read(25'd3);
        chk("top_past_end", 32'(idin[1]), 0);
        hps_end();

        // reset with a DMA data read in flight
        set_ptrs(16'h0401, 16'h0410);
        do_start(bad);
        hps_begin();
        eq0.push_back(16'h0404);
        eq1.push_back(16'h0404);
        din_known = 1'b0;
        ioctl_addr = 25'd5;
        ioctl_rd = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        chk("fetch_dma_outstanding", 32'(dma_rd), 3);
        chk("fetch_wait", 32'(iwait), 3);
        fs_known = 1'b0;
        err_known = 1'b0;
        reset_n = 1'b0;
        ioctl_upload = 1'b0;
        tick(1);
        check_reset("midfetch");
        eq0.delete();
        eq1.delete();
        exp_din = 8'h00; din_known = 1'b1;
        exp_fs = '0; fs_known = 1'b1;
        exp_err = 1'b0; err_known = 1'b1;
        reset_n = 1'b1;
        tick(6);
        chk("late_din0", 32'(idin[0]), 0);
        chk("late_din1", 32'(idin[1]), 0);
        chk("late_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
